// File: rtl/instr_queue.sv
// Instruction FIFO with a falling-edge issue register and an empty-queue bypass.
// Optional IQ_IMM_EN: registers a sign-extended AA:BA immediate alongside the fields.
module instr_queue #(
  parameter int OP_WIDTH  = 4,
  parameter int REG_WIDTH = 4,
  parameter int DEPTH     = 4,
  parameter int IMM_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              IL,
  input  logic [OP_WIDTH+3*REG_WIDTH-1:0]   IR,
  input  logic                              flush,
  input  logic                              NEXT,
  output logic                              full,
  output logic                              overflow,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic                              valid,
  output logic [OP_WIDTH-1:0]               opcode,
  output logic [REG_WIDTH-1:0]              DA,
  output logic [REG_WIDTH-1:0]              AA,
  output logic [REG_WIDTH-1:0]              BA,
  output logic [IMM_WIDTH-1:0]              IMM
);
  localparam int W  = OP_WIDTH + 3*REG_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [W-1:0]  word;
  logic          advance, pop, bypass, push;
  logic [W-1:0]  nxt;

  assign full    = (count == CW'(DEPTH));
  assign advance = !valid || NEXT;
  assign pop     = advance && (count != '0);
  assign bypass  = advance && (count == '0) && IL;
  assign push    = IL && !full && !bypass && !flush;
  assign nxt     = pop ? mem[rd_ptr] : IR;

  assign {opcode, DA, AA, BA} = word;

  // Storage has no reset; occupancy is tracked solely by the pointers and count.
  always_ff @(negedge clk) begin
    if (push) mem[wr_ptr] <= IR;
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      valid    <= 1'b0;
      word     <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      valid    <= 1'b0;
      word     <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= IL && full;
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (pop || bypass) begin
        word  <= nxt;
        valid <= 1'b1;
      end else if (advance) begin
        valid <= 1'b0;
      end
    end
  end

`ifdef IQ_IMM_EN
  logic [IMM_WIDTH-1:0] imm_q;
  always_ff @(negedge clk or posedge reset) begin
    if (reset)                imm_q <= '0;
    else if (flush)           imm_q <= '0;
    else if (pop || bypass)   imm_q <= IMM_WIDTH'($signed(nxt[2*REG_WIDTH-1:0]));
  end
  assign IMM = imm_q;
`else
  assign IMM = '0;
`endif
endmodule

// File: tb/tb_instr_queue.sv
// Bench for instr_queue: directed vector table, async-reset and IMM cases, then
// randomized traffic against a queue-based reference model.
module tb_instr_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, reset = 1'b1;
  logic        IL = 1'b0, flush = 1'b0, NEXT = 1'b0;
  logic [15:0] IR = '0;
  logic        full, overflow, valid;
  logic [2:0]  count;
  logic [3:0]  opcode, DA, AA, BA;
  logic [15:0] IMM;

  int total = 0, bad = 0;

  instr_queue #(.OP_WIDTH(4), .REG_WIDTH(4), .DEPTH(DEPTH), .IMM_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .IL(IL), .IR(IR), .flush(flush), .NEXT(NEXT),
    .full(full), .overflow(overflow), .count(count), .valid(valid),
    .opcode(opcode), .DA(DA), .AA(AA), .BA(BA), .IMM(IMM));

  always #5 clk = ~clk;

  typedef struct {
    logic        il;
    logic [15:0] ir;
    logic        fl;
    logic        nx;
    logic        e_valid;
    logic [15:0] e_word;
    int          e_count;
    logic        e_full;
    logic        e_ovf;
  } vec_t;

  vec_t tv[19];

  function automatic logic [15:0] imm_of(input logic [15:0] w);
`ifdef IQ_IMM_EN
    return {{8{w[7]}}, w[7:0]};
`else
    return 16'h0 & w;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [15:0] ew,
                         input int ec, input logic ef, input logic eo);
    chk({tag, ".valid"}, 32'(valid), 32'(ev));
    chk({tag, ".fields"}, 32'({opcode, DA, AA, BA}), 32'(ew));
    chk({tag, ".count"}, 32'(count), ec);
    chk({tag, ".full"}, 32'(full), 32'(ef));
    chk({tag, ".overflow"}, 32'(overflow), 32'(eo));
    chk({tag, ".imm"}, 32'(IMM), 32'(imm_of(ew)));
  endtask

  // Drive after the rising edge, let the falling edge act, sample just after it.
  task automatic step(input logic il, input logic [15:0] ir, input logic fl, input logic nx);
    @(posedge clk); #1;
    IL = il; IR = ir; flush = fl; NEXT = nx;
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    IL = 0; flush = 0; NEXT = 0; reset = 1;
    @(posedge clk); #1;
    reset = 0;
  endtask

  logic [15:0] q[$];
  logic        m_valid, m_ovf;
  logic [15:0] m_word;

  initial begin
    // valid, word, count, full, ovf after the edge
    tv[0]  = '{1, 16'h1234, 0, 0, 1, 16'h1234, 0, 0, 0};
    tv[1]  = '{1, 16'hA001, 0, 0, 1, 16'h1234, 1, 0, 0};
    tv[2]  = '{1, 16'hA002, 0, 0, 1, 16'h1234, 2, 0, 0};
    tv[3]  = '{1, 16'hA003, 0, 0, 1, 16'h1234, 3, 0, 0};
    tv[4]  = '{1, 16'hA004, 0, 0, 1, 16'h1234, 4, 1, 0};
    tv[5]  = '{1, 16'hA005, 0, 0, 1, 16'h1234, 4, 1, 1};
    tv[6]  = '{0, 16'h0000, 0, 0, 1, 16'h1234, 4, 1, 0};
    tv[7]  = '{1, 16'hA006, 0, 1, 1, 16'hA001, 3, 0, 1};
    tv[8]  = '{0, 16'h0000, 0, 1, 1, 16'hA002, 2, 0, 0};
    tv[9]  = '{0, 16'h0000, 0, 1, 1, 16'hA003, 1, 0, 0};
    tv[10] = '{0, 16'h0000, 0, 1, 1, 16'hA004, 0, 0, 0};
    tv[11] = '{0, 16'h0000, 0, 1, 0, 16'hA004, 0, 0, 0};
    tv[12] = '{1, 16'hB001, 0, 0, 1, 16'hB001, 0, 0, 0};
    tv[13] = '{1, 16'hB002, 0, 0, 1, 16'hB001, 1, 0, 0};
    tv[14] = '{1, 16'hB003, 0, 0, 1, 16'hB001, 2, 0, 0};
    tv[15] = '{1, 16'hB004, 1, 0, 0, 16'h0000, 0, 0, 0};
    tv[16] = '{1, 16'hB085, 0, 0, 1, 16'hB085, 0, 0, 0};
    tv[17] = '{1, 16'hB006, 0, 1, 1, 16'hB006, 0, 0, 0};
    tv[18] = '{0, 16'h0000, 0, 1, 0, 16'hB006, 0, 0, 0};

    #2;
    chk_all("reset", 0, 16'h0, 0, 0, 0);
    @(posedge clk); #1; reset = 0;

    for (int i = 0; i < 19; i++) begin
      step(tv[i].il, tv[i].ir, tv[i].fl, tv[i].nx);
      chk_all($sformatf("vec%0d", i), tv[i].e_valid, tv[i].e_word,
              tv[i].e_count, tv[i].e_full, tv[i].e_ovf);
    end

    // Async reset between edges with three entries queued
    step(1, 16'hC001, 0, 0);
    step(1, 16'hC002, 0, 0);
    step(1, 16'hC003, 0, 0);
    step(1, 16'hC004, 0, 0);
    chk("pre_rst.count", 32'(count), 3);
    @(posedge clk); #1;
    IL = 0; reset = 1;
    #1;
    chk("async_rst.count", 32'(count), 0);
    chk("async_rst.valid", 32'(valid), 0);
    chk("async_rst.fields", 32'({opcode, DA, AA, BA}), 0);
    chk("async_rst.imm", 32'(IMM), 0);
    @(posedge clk); #1; reset = 0;

    // Immediate sign extension through bypass
    step(1, 16'h12F0, 0, 1);
`ifdef IQ_IMM_EN
    chk("imm_neg", 32'(IMM), 32'h0000FFF0);
`else
    chk("imm_neg", 32'(IMM), 0);
`endif
    step(1, 16'h1270, 0, 1);
`ifdef IQ_IMM_EN
    chk("imm_pos", 32'(IMM), 32'h00000070);
`else
    chk("imm_pos", 32'(IMM), 0);
`endif

    // Randomized traffic against the reference queue
    do_reset();
    q.delete(); m_valid = 0; m_word = '0; m_ovf = 0;
    for (int c = 0; c < 400; c++) begin
      logic        il, fl, nx, was_full, adv;
      logic [15:0] ir;
      il = ($urandom_range(0, 99) < 60);
      nx = ($urandom_range(0, 99) < 45);
      fl = ($urandom_range(0, 99) < 4);
      ir = 16'($urandom);
      step(il, ir, fl, nx);
      if (fl) begin
        q.delete(); m_valid = 0; m_word = '0; m_ovf = 0;
      end else begin
        was_full = (q.size() == DEPTH);
        adv = !m_valid || nx;
        m_ovf = il && was_full;
        if (adv && q.size() > 0) begin
          m_word = q.pop_front(); m_valid = 1;
          if (il && !was_full) q.push_back(ir);
        end else if (adv && il) begin
          m_word = ir; m_valid = 1;
        end else begin
          if (adv) m_valid = 0;
          if (il && !was_full) q.push_back(ir);
        end
      end
      chk_all($sformatf("rnd%0d", c), m_valid, m_word, q.size(),
              q.size() == DEPTH, m_ovf);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_queue.md
# instr_queue

Parametrised instruction buffer and issue register: a DEPTH-entry FIFO that absorbs instructions from fetch, plus an output stage that splits the head instruction into opcode and register-address fields for the control unit and register file. It replaces the single-entry instruction register by decoupling fetch from execute with a valid/advance handshake, a flush, and a bypass path for an empty queue. All state changes on the falling edge of clk, so the rising-edge datapath sees stable fields half a cycle later.

## Interface
Parameters:
- OP_WIDTH, 4, opcode field width (instruction MSBs)
- REG_WIDTH, 4, width of each of DA, AA, BA; instruction width W = OP_WIDTH + 3*REG_WIDTH (fields MSB→LSB: opcode, DA, AA, BA)
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- IMM_WIDTH, 16, width of IMM output; must be ≥ 2*REG_WIDTH

Ports:
- clk  in  1  clock; all updates on falling edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- IL  in  1  instruction load request from fetch
- IR  in  W  instruction to load
- flush  in  1  discard queue and issued instruction (branch taken)
- NEXT  in  1  control unit consumed the current instruction
- full  out  1  FIFO holds DEPTH entries; IL is not accepted
- overflow  out  1  one-cycle pulse: IL was dropped because full
- count  out  clog2(DEPTH+1)  FIFO occupancy (excludes issue stage)
- valid  out  1  opcode/DA/AA/BA hold a live instruction
- opcode  out  OP_WIDTH  issued opcode
- DA, AA, BA  out  REG_WIDTH each  issued destination / A / B addresses
- IMM  out  IMM_WIDTH  immediate (see Configuration)

## Operation
- Reset values: FIFO empty, count=0, full=0, overflow=0, valid=0, opcode=DA=AA=BA=0, IMM=0.
- advance = !valid | NEXT. NEXT while valid=0 has no effect.
- Each falling edge, priority order:
  - flush: pointers and count cleared, valid←0, fields←0, IL in same cycle discarded, overflow←0.
  - advance & count>0: fields←FIFO head, pop, valid←1.
  - advance & count=0 & IL: bypass; fields←IR, valid←1, FIFO not written.
  - advance & nothing available: valid←0, fields hold previous values.
  - not advance: fields and valid hold.
- Push: IL & !full & not bypassed & not flush → write IR at tail.
- Simultaneous push and pop: count unchanged, both pointers move; order preserved (pop returns older entry).
- full is evaluated before the edge: IL with full=1 is dropped even if a pop occurs the same edge; overflow←1 for that cycle only.
- Pointers wrap modulo DEPTH; count saturates logically at DEPTH (never exceeds).
- full = (count == DEPTH), combinational from count.

## Timing
- Bypass latency: IL at edge N with empty queue and advance → valid=1 and fields = IR after edge N.
- Queued latency: instruction occupies FIFO ≥1 cycle; issues at first advance edge after all older entries.
- Throughput: one instruction per cycle with NEXT held high.
- Reset mid-operation: asynchronous clear regardless of clk; first load possible at the first falling edge after reset deasserts.
- flush takes effect at the edge it is sampled; valid=0 after that edge.

## Configuration
- IQ_IMM_EN defined: IMM = AA:BA concatenated (2*REG_WIDTH bits) sign-extended to IMM_WIDTH, registered with the fields (updates only when fields load, 0 on reset/flush).
- IQ_IMM_EN undefined: IMM tied to 0; no extension logic or storage.

## Test plan
- Reset then IL=1, IR=0x1234, NEXT=0 → after one falling edge valid=1, opcode=1, DA=2, AA=3, BA=4, count=0 (bypass).
- Hold NEXT=0, push 0xA001,0xA002,0xA003,0xA004 → count=4, full=1; fifth IL 0xA005 → overflow pulses 1 cycle, count stays 4; then NEXT=1 four cycles → fields issue 0xA001..0xA004 in order, valid drops after 0x1234 sequence drains.
- Full queue, IL=1 and NEXT=1 same edge → head popped, new word dropped, overflow=1, count=3.
- Queue count=2, valid=1, assert flush with IL=1 → count=0, valid=0, fields=0, no overflow; next IL bypasses.
- Assert reset asynchronously between edges while count=3 → count, valid, fields go to 0 immediately without a clock edge.
- With IQ_IMM_EN, IR=0x12F0 → IMM=0xFFF0; IR=0x1270 → IMM=0x0070; without macro IMM=0 for both.
